// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: one WIDTH-bit adder shared by NUM_REQ clients
// round-robin grant, latched operands, result under valid/ready
module shared_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_carry,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [ID_W-1:0]   win;
  logic [ID_W:0]     k;
  logic              found;
  logic [ID_W-1:0]   nxt_ptr;

  // first requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (k >= (ID_W+1)'(NUM_REQ))
        k = k - (ID_W+1)'(NUM_REQ);
      if (!found && req[k[ID_W-1:0]]) begin
        found = 1'b1;
        win   = k[ID_W-1:0];
      end
    end
  end

  // pointer moves one past the requester just served
  always_comb begin
    nxt_ptr = res_id + 1'b1;
    if (res_id == ID_W'(NUM_REQ-1))
      nxt_ptr = '0;
  end

  // arbitration / add / handshake FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_r    <= a_in[win*WIDTH +: WIDTH];
            b_r    <= b_in[win*WIDTH +: WIDTH];
            res_id <= win;
            gnt    <= NUM_REQ'(1) << win;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          {res_carry, res_sum} <= {1'b0, a_r} + {1'b0, b_r};
          res_valid <= 1'b1;
          gnt       <= '0;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rr_ptr    <= nxt_ptr;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: directed vectors plus multi-cycle sequences
// for grant order, backpressure and reset mid-operation
module tb_shared_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  shared_adder_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (8),
    .ID_W   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_carry(res_carry),
    .res_id   (res_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] id;
    logic [7:0] sum;
    logic       c;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int w, input logic [7:0] a,
                      input logic [7:0] b);
    a_in = {4{8'hAA}};
    b_in = {4{8'h55}};
    a_in[w*8 +: 8] = a;
    b_in[w*8 +: 8] = b;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".gnt"}, 16'(gnt), 16'h0);
    chk({nm, ".valid"}, 16'(res_valid), 16'h0);
    chk({nm, ".sum"}, 16'(res_sum), 16'h0);
    chk({nm, ".carry"}, 16'(res_carry), 16'h0);
    chk({nm, ".id"}, 16'(res_id), 16'h0);
    chk({nm, ".busy"}, 16'(busy), 16'h0);
  endtask

  task automatic run_vec(input int n, input vec_t t);
    string s;
    s = $sformatf("vec%0d", n);
    @(negedge clk);
    req = t.req;
    res_ready = 1'b1;
    load(int'(t.id), t.a, t.b);
    @(negedge clk);
    chk({s, ".gnt"}, 16'(gnt), 16'(4'b0001 << t.id));
    chk({s, ".busy"}, 16'(busy), 16'h1);
    chk({s, ".valid0"}, 16'(res_valid), 16'h0);
    req = 4'b0000;
    @(negedge clk);
    chk({s, ".valid"}, 16'(res_valid), 16'h1);
    chk({s, ".sum"}, 16'(res_sum), 16'(t.sum));
    chk({s, ".carry"}, 16'(res_carry), 16'(t.c));
    chk({s, ".id"}, 16'(res_id), 16'(t.id));
    chk({s, ".gnt0"}, 16'(gnt), 16'h0);
    @(negedge clk);
    chk({s, ".ret_valid"}, 16'(res_valid), 16'h0);
    chk({s, ".ret_busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    // rr_ptr evolution from reset: 0 ->2 ->1 ->0 ->1 ->0 ->2 ->1 ->3
    v[0] = '{4'b0010, 8'h12, 8'h34, 2'd1, 8'h46, 1'b0};
    v[1] = '{4'b0001, 8'hFF, 8'h01, 2'd0, 8'h00, 1'b1};
    v[2] = '{4'b1000, 8'hFF, 8'hFF, 2'd3, 8'hFE, 1'b1};
    v[3] = '{4'b0001, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0};
    v[4] = '{4'b1001, 8'h80, 8'h80, 2'd3, 8'h00, 1'b1};
    v[5] = '{4'b0110, 8'h7F, 8'h01, 2'd1, 8'h80, 1'b0};
    v[6] = '{4'b0011, 8'h10, 8'h20, 2'd0, 8'h30, 1'b0};
    v[7] = '{4'b1100, 8'hC8, 8'h64, 2'd2, 8'h2C, 1'b1};

    // reset with random inputs
    rst_n = 1'b0;
    req = 4'($urandom);
    a_in = $urandom;
    b_in = $urandom;
    res_ready = 1'($urandom);
    #1;
    chk_zero("rst_now");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_held");
    @(negedge clk);
    req = 4'b0000;
    res_ready = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, v[i]);

    // round-robin with all requesting: order 0,1,2,3,0 every 3 cycles
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(0, 8'h01, 8'h01);
    req = 4'b1111;
    res_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (t % 3 == 0)
        chk($sformatf("rr.t%0d", t), 16'(gnt),
            16'(4'b0001 << ((t / 3) % 4)));
      else
        chk($sformatf("rr.t%0d", t), 16'(gnt), 16'h0);
      if (t == 12) req = 4'b0000;
    end
    @(negedge clk);
    chk("rr.end_busy", 16'(busy), 16'h0);

    // backpressure: rr_ptr now 1, requester 2 wins
    @(negedge clk);
    res_ready = 1'b0;
    req = 4'b0100;
    load(2, 8'h21, 8'h10);
    @(negedge clk);
    chk("bp.gnt", 16'(gnt), 16'b0100);
    req = 4'b0000;
    @(negedge clk);
    chk("bp.valid", 16'(res_valid), 16'h1);
    for (int t = 0; t < 5; t++) begin
      req = (t % 2 == 0) ? 4'b1111 : 4'b0000;
      load(t % 4, 8'(t * 7), 8'hF0);
      @(negedge clk);
      chk($sformatf("bp.valid%0d", t), 16'(res_valid), 16'h1);
      chk($sformatf("bp.sum%0d", t), 16'(res_sum), 16'h31);
      chk($sformatf("bp.carry%0d", t), 16'(res_carry), 16'h0);
      chk($sformatf("bp.id%0d", t), 16'(res_id), 16'h2);
      chk($sformatf("bp.gnt%0d", t), 16'(gnt), 16'h0);
    end
    req = 4'b0000;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp.ret_valid", 16'(res_valid), 16'h0);
    chk("bp.ret_busy", 16'(busy), 16'h0);

    // bring rr_ptr to 2 (rr_ptr 3 -> requester 1 wins)
    run_vec(8, '{4'b0010, 8'h05, 8'h06, 2'd1, 8'h0B, 1'b0});

    // reset in CALC: winner would be 3, after reset 0 must win
    @(negedge clk);
    req = 4'b1001;
    a_in = {8'h40, 8'h00, 8'h00, 8'h03};
    b_in = {8'h40, 8'h00, 8'h00, 8'h04};
    @(negedge clk);
    chk("rc.gnt", 16'(gnt), 16'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rc.async");
    @(negedge clk);
    chk_zero("rc.held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rc.gnt0", 16'(gnt), 16'b0001);
    chk("rc.novalid", 16'(res_valid), 16'h0);
    req = 4'b0000;
    @(negedge clk);
    chk("rc.valid", 16'(res_valid), 16'h1);
    chk("rc.sum", 16'(res_sum), 16'h07);
    chk("rc.id", 16'(res_id), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
